// File: rtl/vpu_pkg.sv
// Shared definitions for the vector unit sequencer and its elementwise ALU:
// opcode values, default widths, FSM state encoding and a leading-zero helper.
package vpu_pkg;

    localparam int DEF_OP_W = 4;
    localparam int FP_W     = 32;

    localparam logic [DEF_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [DEF_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [DEF_OP_W-1:0] OP_RELU = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vpu_seq_state_t;

    // Leading zeros of a 27-bit value; returns 27 when the value is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

endpackage

// File: rtl/vpu_seq_if.sv
// Command, scratchpad-read and scratchpad-write signals of the vector sequencer.
// Every signal is a plain level qualified by its strobe; a command transfers on
// the rising edge where cmd_valid and cmd_ready are both high.
interface vpu_seq_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [ADDR_W-1:0] cmd_src0;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_opcode, cmd_src0, cmd_src1, cmd_dst, cmd_len,
        output rd_data0, rd_data1,
        input  cmd_ready, rd_en, rd_addr0, rd_addr1,
        input  wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_src0, cmd_src1, cmd_dst, cmd_len,
        input  rd_data0, rd_data1,
        output cmd_ready, rd_en, rd_addr0, rd_addr1,
        output wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/vpu_op.sv
// Combinational FP32 elementwise ALU: ADD, SUB (round-to-nearest-even,
// subnormals flushed to zero) and RELU. Output is zero while start is low.
module vpu_op
    import vpu_pkg::*;
#(
    parameter int OP_W = DEF_OP_W
) (
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] result_out
);

    logic        sa, sb, eff_sub, a_ge, big_s, sticky, round_up, underflow;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea, eb, big_e, sml_e, diff;
    logic [22:0] ma, mb, frac;
    logic [23:0] big_m, sml_m;
    logic [4:0]  sh, lz;
    logic [53:0] wide;
    logic [26:0] aligned, norm;
    logic [27:0] sum;
    logic [9:0]  exp_n, exp_r;
    logic [24:0] mant_r;
    logic [FP_W-1:0] add_res, res;

    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ (opcode == OP_W'(OP_SUB));
        ea    = a[30:23];
        eb    = b[30:23];
        ma    = a[22:0];
        mb    = b[22:0];
        a_nan = (ea == 8'hFF) && (ma != 23'd0);
        b_nan = (eb == 8'hFF) && (mb != 23'd0);
        a_inf = (ea == 8'hFF) && (ma == 23'd0);
        b_inf = (eb == 8'hFF) && (mb == 23'd0);

        a_ge  = {ea, ma} >= {eb, mb};
        big_s = a_ge ? sa : sb;
        big_e = a_ge ? ea : eb;
        sml_e = a_ge ? eb : ea;
        big_m = {1'b1, (a_ge ? ma : mb)};
        sml_m = {1'b1, (a_ge ? mb : ma)};

        // Align the smaller operand keeping guard/round bits plus a sticky OR.
        diff    = big_e - sml_e;
        sh      = (diff > 8'd31) ? 5'd31 : diff[4:0];
        wide    = {sml_m, 30'd0} >> sh;
        sticky  = |wide[26:0];
        aligned = wide[53:27] | {26'd0, sticky};

        eff_sub = sa ^ sb;
        sum     = eff_sub ? ({1'b0, big_m, 3'b000} - {1'b0, aligned})
                          : ({1'b0, big_m, 3'b000} + {1'b0, aligned});
        lz      = lzc27(sum[26:0]);

        if (sum[27]) begin
            norm      = {sum[27:2], sum[1] | sum[0]};
            exp_n     = {2'b00, big_e} + 10'd1;
            underflow = 1'b0;
        end else begin
            norm      = sum[26:0] << lz;
            exp_n     = {2'b00, big_e} - {5'd0, lz};
            underflow = ({2'b00, big_e} <= {5'd0, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        exp_r    = exp_n + {9'd0, mant_r[24]};
        frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            add_res = 32'h7FC0_0000;
        end else if (a_inf) begin
            add_res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            add_res = {sb, 8'hFF, 23'd0};
        end else if ((ea == 8'd0) && (eb == 8'd0)) begin
            add_res = {sa & sb, 31'd0};
        end else if (ea == 8'd0) begin
            add_res = {sb, eb, mb};
        end else if (eb == 8'd0) begin
            add_res = a;
        end else if (sum == 28'd0) begin
            add_res = '0;
        end else if (underflow) begin
            add_res = {big_s, 31'd0};
        end else if (exp_r >= 10'd255) begin
            add_res = {big_s, 8'hFF, 23'd0};
        end else begin
            add_res = {big_s, exp_r[7:0], frac};
        end
    end

    always_comb begin
        res = '0;
        if ((opcode == OP_W'(OP_ADD)) || (opcode == OP_W'(OP_SUB))) begin
            res = add_res;
        end else if (opcode == OP_W'(OP_RELU)) begin
            res = a[31] ? '0 : a;
        end
        result_out = start ? res : '0;
    end

endmodule

// File: rtl/vpu_seq.sv
// Vector command sequencer: streams operand pairs from the scratchpad through
// vpu_op and writes one result per cycle back, one command at a time.
module vpu_seq
    import vpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = DEF_OP_W,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    vpu_seq_if.slave       bus,
    output vpu_seq_state_t dbg_state
);

    vpu_seq_state_t    state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] src0_q, src0_d, src1_q, src1_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d, rd_vld_q, rd_vld_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] op_result;
    logic              accept, cmd_legal;

    vpu_op #(.OP_W(OP_W)) u_op (
        .start      (rd_vld_q),
        .opcode     (op_q),
        .a          (bus.rd_data0),
        .b          (bus.rd_data1),
        .result_out (op_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
            rd_vld_q  <= rd_vld_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        cmd_legal = (bus.cmd_opcode == OP_W'(OP_ADD)) ||
                    (bus.cmd_opcode == OP_W'(OP_SUB)) ||
                    (bus.cmd_opcode == OP_W'(OP_RELU));
        accept    = bus.cmd_valid && (state_q == ST_IDLE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ((bus.cmd_len == '0) || !cmd_legal) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_cnt_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
            end
            // wr_cnt reaches len on the cycle the last write is on the bus.
            ST_DRAIN: begin
                if (wr_cnt_q == len_q) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        dst_d     = dst_q;
        len_d     = len_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rd_vld_d  = (state_q == ST_RUN);
        wr_en_d   = rd_vld_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            op_d     = bus.cmd_opcode;
            src0_d   = bus.cmd_src0;
            src1_d   = bus.cmd_src1;
            dst_d    = bus.cmd_dst;
            len_d    = bus.cmd_len;
            err_d    = !cmd_legal;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
        if (state_q == ST_RUN) begin
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
        end
        if (rd_vld_q) begin
            wr_data_d = op_result;
            wr_addr_d = dst_q + ADDR_W'(wr_cnt_q);
            wr_cnt_d  = wr_cnt_q + LEN_W'(1);
        end
    end

    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
        bus.rd_en     = (state_q == ST_RUN);
        bus.rd_addr0  = (state_q == ST_RUN) ? src0_q + ADDR_W'(rd_cnt_q) : '0;
        bus.rd_addr1  = (state_q == ST_RUN) ? src1_q + ADDR_W'(rd_cnt_q) : '0;
        bus.wr_en     = wr_en_q;
        bus.wr_addr   = wr_addr_q;
        bus.wr_data   = wr_data_q;
        bus.err       = err_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_vpu_seq.sv
// Directed bench for vpu_seq: a preloaded read-only scratchpad model feeds the
// sequencer and every output is checked cycle by cycle against hand values.
module tb_vpu_seq;
    import vpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vpu_seq_if #(.DATA_W(32), .OP_W(4), .ADDR_W(8), .LEN_W(8)) bus ();
    vpu_seq_state_t dbg_state;

    vpu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [31:0] src_mem [256];
    logic [31:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    // Scratchpad read ports: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data0 <= src_mem[bus.rd_addr0];
            bus.rd_data1 <= src_mem[bus.rd_addr1];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] d, input logic [7:0] len);
        bus.cmd_opcode = op;
        bus.cmd_src0   = s0;
        bus.cmd_src1   = s1;
        bus.cmd_dst    = d;
        bus.cmd_len    = len;
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic start_cmd(input logic [3:0] op, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] d, input logic [7:0] len);
        drive_cmd(op, s0, s1, d, len);
        for (int w = 0; w < 50 && !bus.cmd_ready; w++) tick();
        chk("cmd_ready_at_T", bus.cmd_ready, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr0", bus.rd_addr0, 0);
        chk("rst_rd_addr1", bus.rd_addr1, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_state", dbg_state, ST_IDLE);
    endtask

    // Called in handshake cycle T; returns in T+4+len (or T+2) with cmd_ready high.
    task automatic follow_cmd(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] d,
                              input logic [7:0] len, input bit act, input bit want_err,
                              input bit chain, input logic [3:0] n_op, input logic [7:0] n_s0,
                              input logic [7:0] n_s1, input logic [7:0] n_d, input logic [7:0] n_len);
        int last;
        logic [7:0] a0, a1, wa;
        logic [31:0] want;
        bit rd_exp, wr_exp;
        last = act ? int'(len) + 3 : 1;
        for (int k = 1; k <= last + 1; k++) begin
            tick();
            if (k == 1) begin
                if (chain) drive_cmd(n_op, n_s0, n_s1, n_d, n_len);
                else bus.cmd_valid = 1'b0;
            end
            rd_exp = act && (k <= int'(len));
            wr_exp = act && (k >= 3) && (k <= int'(len) + 2);
            chk("rd_en", bus.rd_en, rd_exp);
            if (rd_exp) begin
                a0 = s0 + 8'(k - 1);
                a1 = s1 + 8'(k - 1);
                chk("rd_addr0", bus.rd_addr0, a0);
                chk("rd_addr1", bus.rd_addr1, a1);
            end
            chk("wr_en", bus.wr_en, wr_exp);
            if (wr_exp) begin
                wa   = d + 8'(k - 3);
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
                chk("wr_addr", bus.wr_addr, wa);
                chk("wr_data", bus.wr_data, want);
            end
            chk("done", bus.done, k == last);
            if (k == last) chk("err_at_done", bus.err, want_err);
            chk("busy", bus.busy, k <= last);
            chk("cmd_ready", bus.cmd_ready, k == last + 1);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_src0  = '0;
        bus.cmd_src1  = '0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        for (int i = 0; i < 256; i++) src_mem[i] = 32'h0BAD_0000 + 32'(i);
        for (int i = 16; i < 32; i++) src_mem[i] = 32'h3F80_0000;
        for (int i = 32; i < 48; i++) src_mem[i] = 32'h4000_0000;
        src_mem[8'h40] = 32'hC000_0000;
        src_mem[8'h41] = 32'h3F80_0000;
        src_mem[8'h50] = 32'h1234_5678;
        src_mem[8'h51] = 32'h89AB_CDEF;
        src_mem[8'h70] = 32'h4040_0000;
        src_mem[8'h71] = 32'h3F80_0000;
        src_mem[8'h80] = 32'h3F80_0000;
        src_mem[8'h81] = 32'h4000_0000;

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs();

        // ADD 1.0 + 2.0 over four elements
        repeat (4) exp_q.push_back(32'h4040_0000);
        start_cmd(OP_ADD, 8'h10, 8'h20, 8'h30, 8'd4);
        follow_cmd(8'h10, 8'h20, 8'h30, 8'd4, 1, 0, 0, 0, 0, 0, 0, 0);

        // RELU: negative clamps to zero, positive passes, src1 ignored
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h3F80_0000);
        start_cmd(OP_RELU, 8'h40, 8'h50, 8'h60, 8'd2);
        follow_cmd(8'h40, 8'h50, 8'h60, 8'd2, 1, 0, 0, 0, 0, 0, 0, 0);

        // SUB: 3-1=2, 1-2=-1
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'hBF80_0000);
        start_cmd(OP_SUB, 8'h70, 8'h80, 8'hD0, 8'd2);
        follow_cmd(8'h70, 8'h80, 8'hD0, 8'd2, 1, 0, 0, 0, 0, 0, 0, 0);

        // ADD with exponent carry: 3+1=4, 1+2=3
        exp_q.push_back(32'h4080_0000);
        exp_q.push_back(32'h4040_0000);
        start_cmd(OP_ADD, 8'h70, 8'h80, 8'hD8, 8'd2);
        follow_cmd(8'h70, 8'h80, 8'hD8, 8'd2, 1, 0, 0, 0, 0, 0, 0, 0);

        // len 0: no traffic, done at T+1
        start_cmd(OP_ADD, 8'h10, 8'h20, 8'h30, 8'd0);
        follow_cmd(8'h10, 8'h20, 8'h30, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0);

        // illegal opcode: no traffic, err set and sticky
        start_cmd(4'd4, 8'h10, 8'h20, 8'h30, 8'd5);
        follow_cmd(8'h10, 8'h20, 8'h30, 8'd5, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("err_sticky", bus.err, 1);

        // destination wraps past the top of the address space
        repeat (4) exp_q.push_back(32'h4040_0000);
        start_cmd(OP_ADD, 8'h10, 8'h20, 8'hFE, 8'd4);
        follow_cmd(8'h10, 8'h20, 8'hFE, 8'd4, 1, 0, 0, 0, 0, 0, 0, 0);

        // back-to-back: second command waits with cmd_valid held
        repeat (2) exp_q.push_back(32'h4040_0000);
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'hBF80_0000);
        start_cmd(OP_ADD, 8'h10, 8'h20, 8'hB0, 8'd2);
        follow_cmd(8'h10, 8'h20, 8'hB0, 8'd2, 1, 0, 1, OP_SUB, 8'h70, 8'h80, 8'hC0, 8'd2);
        chk("b2b_valid_held", bus.cmd_valid, 1);
        follow_cmd(8'h70, 8'h80, 8'hC0, 8'd2, 1, 0, 0, 0, 0, 0, 0, 0);

        // reset dropped mid-command at T+3 of a len=8 command
        start_cmd(OP_ADD, 8'h10, 8'h20, 8'h90, 8'd8);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_wr_en", bus.wr_en, 1);
        chk("pre_rst_rd_en", bus.rd_en, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("in_rst_wr_en", bus.wr_en, 0);
            chk("in_rst_rd_en", bus.rd_en, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_wr_en", bus.wr_en, 0);
        chk("post_rst_ready", bus.cmd_ready, 1);
        repeat (2) exp_q.push_back(32'h4040_0000);
        start_cmd(OP_ADD, 8'h10, 8'h20, 8'hA0, 8'd2);
        follow_cmd(8'h10, 8'h20, 8'hA0, 8'd2, 1, 0, 0, 0, 0, 0, 0, 0);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_seq.md
# vpu_seq

Command-driven sequencer for the vector unit's elementwise ALU (`vpu_op`). It accepts one vector command at a time and streams operand pairs from a dual-read scratchpad through a single `vpu_op` instance. Results go back to the scratchpad at one element per cycle. It sits between the TPU control path, which issues commands, and the VPU scratchpad, which owns the read and write ports.

## Interface
Parameters:
- DATA_W, 32, element width (FP32)
- OP_W, 4, opcode width
- ADDR_W, 8, scratchpad word address width
- LEN_W, 8, element count width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_opcode  in  OP_W  0=ADD, 1=SUB, 2=RELU, others illegal
- cmd_src0, cmd_src1, cmd_dst  in  ADDR_W  base addresses
- cmd_len  in  LEN_W  element count, 0 allowed
- rd_en  out  1  scratchpad read strobe (both ports)
- rd_addr0, rd_addr1  out  ADDR_W  read addresses
- rd_data0, rd_data1  in  DATA_W  read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- busy  out  1  high from accept until done completes
- done  out  1  one-cycle completion pulse
- err  out  1  sticky until next accept: last command had an illegal opcode

## Operation
- States: IDLE, RUN, DRAIN, DONE. cmd_ready = (state==IDLE).
- IDLE: on cmd_valid&&cmd_ready, latch opcode/src0/src1/dst/len and clear err.
  - len==0 or illegal opcode goes to DONE, sets err if illegal, and issues no reads or writes.
  - Otherwise go to RUN with element counter=0.
- RUN: each cycle assert rd_en with rd_addr0=src0+i and rd_addr1=src1+i, then i++. After issuing i=len-1, go to DRAIN.
- Pipeline stage 1: a registered rd_en copy (rd_vld) drives `vpu_op.start`. rd_data0/1 and the latched opcode drive `vpu_op`.
- Pipeline stage 2: on rd_vld, register `result_out` into wr_data, with wr_en=1 and wr_addr=dst+j, where j is a separate write counter.
- DRAIN: wait until the last write has been issued, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W, so addresses wrap silently.
- In-place operation (dst==src0 or dst==src1) is legal. Element i is read before element i is written, and later reads never hit an already-written address when dst==src.
- cmd_valid during busy is ignored (not accepted). A command held through DONE is accepted in the first IDLE cycle.

## Timing
- Handshake edge is cycle T.
- Read of element i is issued in cycle T+1+i, data returns in T+2+i, and the write is issued in T+3+i.
- done is asserted in cycle T+3+len. cmd_ready is high again in T+4+len.
- For len==0 or an illegal opcode, done is asserted in T+1 and cmd_ready is high in T+2.
- Throughput is 1 element/cycle, with no bubbles inside a command.
- Reset values: cmd_ready=1; every other output is 0.
- Reset asserted mid-command returns to IDLE immediately. No further rd_en or wr_en is issued and the partial results already written are left in place.

## Structure
- Shared package `vpu_pkg`: opcode constants OP_ADD/OP_SUB/OP_RELU, the OP_W default, and the state enum `vpu_seq_state_t`. `vpu_op` takes its opcode values from the same package.
- One sub-module, `vpu_op`, instantiated once. Its `start` is tied to rd_vld.
- All other logic (FSM, two counters, the pipeline register) lives in `vpu_seq`.

## Test plan
- ADD, len=4, src0=0x10, src1=0x20, dst=0x30. Every src0 word is 0x3F800000 and every src1 word is 0x40000000.
  - Expect four writes of 0x40400000 to 0x30..0x33 in T+3..T+6, done at T+7, err=0.
- RELU, len=2. src0 words are 0xC0000000 and 0x3F800000.
  - Expect writes of 0x00000000 then 0x3F800000, with src1 ignored.
- len=0, and separately opcode=4 with len=5.
  - Expect no rd_en or wr_en, done at T+1, err=0 and err=1 respectively.
- ADD, len=4, dst=0xFE.
  - Expect wr_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Back-to-back commands, with cmd_valid held high and a second command waiting.
  - Expect the second accept exactly at T+4+len and no overlap of wr_en between commands.
- rst_n dropped at T+3 of a len=8 command.
  - Expect outputs at reset values asynchronously, no wr_en after the reset, and a fresh command after release completing normally.
